dcache_wb: RTL and testbench

- Direct-mapped, write-back, write-allocate data cache between the pipeline memory stage and the line-wide main-memory port.
- Serves loads/stores addressed by ALUOutM/WriteDataM. Returns the read word combinationally on a hit.
- Drives dhit low to freeze the whole pipeline while a miss is being serviced.

---
 rtl/dcache_wb.sv | 129 ++++++++++++
 tb/tb_dcache_wb.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with a line-wide memory port.
// Load hits return combinationally; a miss holds dhit low until the line has been refilled.
module dcache_wb #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cpu_rd,
  input  logic         cpu_wr,
  input  logic         cpu_byte,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         dhit,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t               stateReg;
  logic [LINES-1:0]     validReg;
  logic [LINES-1:0]     dirtyReg;
  logic [TAG_BITS-1:0]  tagMem  [LINES];
  logic [127:0]         dataMem [LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   cpuTag;
  logic [1:0]            wordSel;
  logic [1:0]            laneSel;
  logic [127:0]          lineData;
  logic [TAG_BITS-1:0]   lineTag;
  logic                  hit;
  logic                  req;
  logic                  idle;
  logic [31:0]           oldWord;
  logic [31:0]           newWord;
  logic [127:0]          newLine;

  assign index    = cpu_addr[INDEX_BITS+3:4];
  assign cpuTag   = cpu_addr[31:INDEX_BITS+4];
  assign wordSel  = cpu_addr[3:2];
  assign laneSel  = cpu_addr[1:0];
  assign lineData = dataMem[index];
  assign lineTag  = tagMem[index];
  assign hit      = validReg[index] && (lineTag == cpuTag);
  assign req      = cpu_rd | cpu_wr;
  assign idle     = (stateReg == IDLE);
  assign oldWord  = lineData[{wordSel, 5'b00000} +: 32];

  // Big-endian lanes: lane 0 is the top byte, so the bit offset is (3 - lane) * 8.
  always_comb begin
    newWord = cpu_wdata;
    if (cpu_byte) begin
      newWord = oldWord;
      newWord[{~laneSel, 3'b000} +: 8] = cpu_wdata[7:0];
    end
    newLine = lineData;
    newLine[{wordSel, 5'b00000} +: 32] = newWord;
  end

  assign dhit      = idle && (!req || hit);
  assign cpu_rdata = (idle && cpu_rd && hit) ? oldWord : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stateReg  <= IDLE;
      validReg  <= '0;
      dirtyReg  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (cpu_wr) begin
                dataMem[index]  <= newLine;
                dirtyReg[index] <= 1'b1;
              end
            end else if (validReg[index] && dirtyReg[index]) begin
              stateReg  <= WRITEBACK;
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= {lineTag, index, 4'b0000};
              mem_wdata <= lineData;
            end else begin
              stateReg  <= ALLOCATE;
              mem_req   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= {cpuTag, index, 4'b0000};
            end
          end
        end
        WRITEBACK: begin
          // mem_req stays high; the fetch follows the write-back directly.
          if (mem_ready) begin
            stateReg  <= ALLOCATE;
            mem_we    <= 1'b0;
            mem_addr  <= {cpuTag, index, 4'b0000};
            mem_wdata <= '0;
          end
        end
        ALLOCATE: begin
          if (mem_ready) begin
            dataMem[index]  <= mem_rdata;
            tagMem[index]   <= cpuTag;
            validReg[index] <= 1'b1;
            dirtyReg[index] <= 1'b0;
            stateReg        <= IDLE;
            mem_req         <= 1'b0;
            mem_addr        <= '0;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: stimulus queues expected CPU reads and memory transactions,
// monitors pop and compare them when the cache completes a request or a memory handshake.
module tb_dcache_wb;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         cpu_rd = 1'b0;
  logic         cpu_wr = 1'b0;
  logic         cpu_byte = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [31:0]  cpu_rdata;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata = '0;
  logic         mem_ready = 1'b0;

  dcache_wb #(.INDEX_BITS(4)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .dhit(dhit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         chk;
  } memTxn_t;

  int checks = 0;
  int errors = 0;
  int memLat = 3;
  bit randomReady = 1'b0;
  int memCnt = 0;
  logic [127:0] memStore [logic [31:0]];
  logic [31:0]  cpuExpQ [$];
  memTxn_t      memExpQ [$];
  memTxn_t      monTxn;
  logic [31:0]  monExp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] memRead(input logic [31:0] a);
    if (memStore.exists(a)) return memStore[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  // Memory model: mem_ready in the memLat-th cycle of an asserted mem_req.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      memCnt++;
      if (memCnt == memLat) begin
        mem_ready = 1'b1;
        memCnt = 0;
        if (mem_we) memStore[mem_addr] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
      end
      mem_rdata = memRead(mem_addr);
    end else begin
      memCnt = 0;
      mem_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  // Monitors: memory handshakes and CPU request completions.
  always @(negedge clk) begin
    if (mem_req && mem_ready) begin
      if (memExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL memTxn unexpected actual we=%b addr=%h required none", mem_we, mem_addr);
      end else begin
        monTxn = memExpQ.pop_front();
        check("memWe", mem_we, monTxn.we);
        check("memAddr", mem_addr, monTxn.addr);
        if (monTxn.chk) check("memWdata", mem_wdata, monTxn.wdata);
      end
    end
    if (reset && (cpu_rd || cpu_wr) && dhit) begin
      if (cpuExpQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cpuDone unexpected actual addr=%h required none", cpu_addr);
      end else begin
        monExp = cpuExpQ.pop_front();
        check("cpuRdata", cpu_rdata, monExp);
      end
    end
  end

  task automatic pushMem(input logic we, input logic [31:0] a, input logic [127:0] d, input logic chk);
    memTxn_t t;
    t.we = we; t.addr = a; t.wdata = d; t.chk = chk;
    memExpQ.push_back(t);
  endtask

  // Called just after a rising edge; returns just after the edge that retires the request.
  task automatic issue(input bit rd, input bit wr, input bit by, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] expRdata, input int expStalls);
    int stalls = 0;
    cpuExpQ.push_back(expRdata);
    cpu_rd = rd; cpu_wr = wr; cpu_byte = by; cpu_addr = addr; cpu_wdata = wdata;
    while (1) begin
      @(negedge clk);
      if (dhit) break;
      stalls++;
      if (stalls > 100) break;
    end
    check("stallCycles", stalls, expStalls);
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_byte = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    memStore[32'h40]  = 128'h44444444_33333333_22222222_11111111;
    memStore[32'h140] = 128'h88888888_77777777_66666666_55555555;
    memStore[32'h240] = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

    @(posedge clk); #1;
    @(negedge clk);
    check("rstDhit", dhit, 1'b1);
    check("rstMemReq", mem_req, 1'b0);
    check("rstMemWe", mem_we, 1'b0);
    check("rstMemAddr", mem_addr, 32'h0);
    check("rstRdata", cpu_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Cold load, then hit in the same line.
    pushMem(1'b0, 32'h40, '0, 1'b0);
    issue(1, 0, 0, 32'h40, 32'h0, 32'h11111111, 4);
    issue(1, 0, 0, 32'h4C, 32'h0, 32'h44444444, 0);

    // Byte store hit (lane 01), then read back.
    issue(0, 1, 1, 32'h41, 32'hAB, 32'h0, 0);
    issue(1, 0, 0, 32'h40, 32'h0, 32'h11AB1111, 0);

    // Dirty conflict: write-back of the modified line, then fetch.
    pushMem(1'b1, 32'h40, 128'h44444444_33333333_22222222_11AB1111, 1'b1);
    pushMem(1'b0, 32'h140, '0, 1'b0);
    issue(1, 0, 0, 32'h140, 32'h0, 32'h55555555, 7);

    // Clean conflicts: fetch only; the first one proves the write-back reached memory.
    pushMem(1'b0, 32'h40, '0, 1'b0);
    issue(1, 0, 0, 32'h40, 32'h0, 32'h11AB1111, 4);
    pushMem(1'b0, 32'h240, '0, 1'b0);
    issue(1, 0, 0, 32'h244, 32'h0, 32'hBBBBBBBB, 4);

    // Word store, combined rd/wr store, remaining byte lanes.
    issue(0, 1, 0, 32'h248, 32'h12345678, 32'h0, 0);
    issue(1, 1, 0, 32'h248, 32'hCAFEF00D, 32'h12345678, 0);
    issue(1, 0, 0, 32'h248, 32'h0, 32'hCAFEF00D, 0);
    issue(0, 1, 1, 32'h24B, 32'h5A, 32'h0, 0);
    issue(1, 0, 0, 32'h248, 32'h0, 32'hCAFEF05A, 0);
    issue(0, 1, 1, 32'h240, 32'h77, 32'h0, 0);
    issue(1, 0, 0, 32'h240, 32'h0, 32'h77AAAAAA, 0);
    issue(0, 1, 1, 32'h246, 32'hFFFFFF99, 32'h0, 0);
    issue(1, 0, 0, 32'h244, 32'h0, 32'hBBBB99BB, 0);

    // Different index with a longer memory latency.
    memLat = 5;
    pushMem(1'b0, 32'h7F0, '0, 1'b0);
    issue(1, 0, 0, 32'h7F4, 32'h0, 32'h000007F4, 6);

    // Reset while a fetch is outstanding.
    memLat = 20;
    cpu_rd = 1'b1; cpu_addr = 32'h300;
    @(negedge clk);
    check("abortMissDhit", dhit, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abortReqBefore", mem_req, 1'b1);
    check("abortAddrBefore", mem_addr, 32'h300);
    @(posedge clk); #1;
    reset = 1'b0; cpu_rd = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abortReqAfter", mem_req, 1'b0);
    check("abortAddrAfter", mem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    memLat = 3;
    pushMem(1'b0, 32'h300, '0, 1'b0);
    issue(1, 0, 0, 32'h300, 32'h0, 32'h00000300, 4);
    pushMem(1'b0, 32'h40, '0, 1'b0);
    issue(1, 0, 0, 32'h4C, 32'h0, 32'h44444444, 4);

    // Idle with stray mem_ready pulses.
    randomReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idleDhit", dhit, 1'b1);
      check("idleMemReq", mem_req, 1'b0);
      check("idleRdata", cpu_rdata, 32'h0);
    end
    randomReady = 1'b0;
    @(posedge clk); #1;

    check("cpuQueueDrained", cpuExpQ.size(), 0);
    check("memQueueDrained", memExpQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
